// File: rtl/alu_core_pipe.sv
// Three-stage signed ALU: operand register, multiply, then add/logic into the P register.
// Every opcode has the same latency; MACC feeds back from the P register itself.
module alu_core_pipe #(
    parameter int A_W = 30,
    parameter int B_W = 18,
    parameter int P_W = 48,
    parameter int SAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce_i,
    input  logic           valid_i,
    input  logic [2:0]     op_i,
    input  logic           acc_clr_i,
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    input  logic [P_W-1:0] c_i,
    output logic [P_W-1:0] p_o,
    output logic           valid_o,
    output logic           ovf_o
);
    localparam int M_W    = A_W + B_W;
    localparam int STAGES = 3;

    if (A_W + B_W > P_W) begin : g_width_check
        $error("alu_core_pipe: A_W+B_W must not exceed P_W");
    end

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_MACC, OP_MADD, OP_AND, OP_OR, OP_XOR
    } op_e;

    logic [STAGES:1] vld_pipe;

    // S1 operand registers
    logic [A_W-1:0] a1;
    logic [B_W-1:0] b1;
    logic [P_W-1:0] c1;
    op_e            op1;
    logic           clr1;

    // S2 product and carried operands
    logic [M_W-1:0] m2;
    logic [P_W-1:0] a2, c2;
    op_e            op2;
    logic           clr2;

    logic [M_W-1:0] a_m, b_m, prod;
    logic [P_W:0]   a_x, c_x, m_x, q_x, res;
    logic [P_W-1:0] p_nxt;
    logic           arith, ovf;

    assign a_m  = {{B_W{a1[A_W-1]}}, a1};
    assign b_m  = {{A_W{b1[B_W-1]}}, b1};
    assign prod = $signed(a_m) * $signed(b_m);

    always_comb begin
        a_x   = {a2[P_W-1], a2};
        c_x   = {c2[P_W-1], c2};
        m_x   = {{(P_W+1-M_W){m2[M_W-1]}}, m2};
        q_x   = {p_o[P_W-1], p_o};
        res   = '0;
        arith = 1'b1;
        case (op2)
            OP_ADD:  res = a_x + c_x;
            OP_SUB:  res = c_x - a_x;
            OP_MUL:  res = m_x;
            OP_MACC: res = (clr2 ? '0 : q_x) + m_x;
            OP_MADD: res = m_x + c_x;
            OP_AND:  begin res = a_x & c_x; arith = 1'b0; end
            OP_OR:   begin res = a_x | c_x; arith = 1'b0; end
            OP_XOR:  begin res = a_x ^ c_x; arith = 1'b0; end
        endcase
        // One guard bit is enough: every arithmetic result fits in P_W+1 bits.
        ovf   = arith & (res[P_W] ^ res[P_W-1]);
        p_nxt = res[P_W-1:0];
        if (SAT != 0 && ovf)
            p_nxt = res[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            a1 <= '0; b1 <= '0; c1 <= '0; op1 <= OP_ADD; clr1 <= 1'b0;
            m2 <= '0; a2 <= '0; c2 <= '0; op2 <= OP_ADD; clr2 <= 1'b0;
            p_o   <= '0;
            ovf_o <= 1'b0;
        end else if (ce_i) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], valid_i};
            a1   <= a_i;
            b1   <= b_i;
            c1   <= c_i;
            op1  <= op_e'(op_i);
            clr1 <= acc_clr_i;
            m2   <= prod;
            a2   <= {{(P_W-A_W){a1[A_W-1]}}, a1};
            c2   <= c1;
            op2  <= op1;
            clr2 <= clr1;
            // P only moves on a valid beat, so bubbles never disturb the accumulator.
            if (vld_pipe[2]) begin
                p_o   <= p_nxt;
                ovf_o <= ovf;
            end
        end
    end

    assign valid_o = vld_pipe[STAGES];

endmodule
